// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: takes traps and mret from the hazard controller,
// redirects fetch, and services Zicsr accesses plus the mcycle/minstret counters.
module trap_csr_unit #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter int unsigned HART_ID     = 0,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        trapTake,
   input  logic [3:0]  trapCause,
   input  logic [31:0] trapPC,
   input  logic [31:0] trapValue,
   input  logic        mretSignal,
   input  logic        stallControl,
   input  logic        retireValid,
   input  logic        csrValid,
   input  logic [1:0]  csrOp,
   input  logic [11:0] csrAddress,
   input  logic [31:0] csrWriteData,
   output logic [31:0] csrReadData,
   output logic        csrIllegal,
   output logic        redirectValid,
   output logic [31:0] redirectPC,
   output logic        mstatusMIE
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   typedef enum logic {
      IDLE,
      REDIRECT
   } state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [3:0]  mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic [31:0] csr_rdata;
   logic        csr_known;
   logic        csr_readonly;
   logic        csr_modifies;
   logic [31:0] csr_wval;
   logic        csr_we;

   // Read mux returns the pre-update value; low bits of mtvec/mepc are forced to zero.
   always_comb begin
      csr_rdata    = 32'h0;
      csr_known    = 1'b1;
      csr_readonly = 1'b0;
      case (csrAddress)
         ADDR_MSTATUS:   csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
         ADDR_MISA: begin
            csr_rdata    = MISA_VALUE;
            csr_readonly = 1'b1;
         end
         ADDR_MTVEC:     csr_rdata = {mtvec_q[31:2], 2'b00};
         ADDR_MSCRATCH:  csr_rdata = mscratch_q;
         ADDR_MEPC:      csr_rdata = {mepc_q[31:2], 2'b00};
         ADDR_MCAUSE:    csr_rdata = {28'b0, mcause_q};
         ADDR_MTVAL:     csr_rdata = mtval_q;
         ADDR_MCYCLE:    csr_rdata = mcycle_q[31:0];
         ADDR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
         ADDR_MINSTRET:  csr_rdata = minstret_q[31:0];
         ADDR_MINSTRETH: csr_rdata = minstret_q[63:32];
         ADDR_MHARTID: begin
            csr_rdata    = 32'(HART_ID);
            csr_readonly = 1'b1;
         end
         default:        csr_known = 1'b0;
      endcase
   end

   always_comb begin
      csr_modifies = (csrOp == 2'd1) || (csrOp[1] && (csrWriteData != 32'h0));
      csrIllegal   = csrValid && (!csr_known || (csr_readonly && csr_modifies));
      case (csrOp)
         2'd1:    csr_wval = csrWriteData;
         2'd2:    csr_wval = csr_rdata | csrWriteData;
         2'd3:    csr_wval = csr_rdata & ~csrWriteData;
         default: csr_wval = csr_rdata;
      endcase
      csr_we = csrValid && (csrOp != 2'd0) && !stallControl && !trapTake && !csrIllegal;
   end

   // A trap or mret is applied after the CSR write so it owns mstatus that cycle.
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_d       = mtvec_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      mcycle_d      = mcycle_q + 64'd1;
      minstret_d    = minstret_q + {63'b0, retireValid};
      redirect_pc_d = redirect_pc_q;

      if (csr_we) begin
         case (csrAddress)
            ADDR_MSTATUS: begin
               mie_d  = csr_wval[3];
               mpie_d = csr_wval[7];
            end
            ADDR_MTVEC:     mtvec_d    = csr_wval;
            ADDR_MSCRATCH:  mscratch_d = csr_wval;
            ADDR_MEPC:      mepc_d     = csr_wval;
            ADDR_MCAUSE:    mcause_d   = csr_wval[3:0];
            ADDR_MTVAL:     mtval_d    = csr_wval;
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wval};
            ADDR_MCYCLEH:   mcycle_d   = {csr_wval, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wval};
            ADDR_MINSTRETH: minstret_d = {csr_wval, minstret_q[31:0]};
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (trapTake) begin
               mepc_d        = trapPC & ~32'h3;
               mcause_d      = trapCause;
               mtval_d       = trapValue;
               mpie_d        = mie_q;
               mie_d         = 1'b0;
               redirect_pc_d = mtvec_q & ~32'h3;
               state_d       = REDIRECT;
            end else if (mretSignal) begin
               mie_d         = mpie_q;
               mpie_d        = 1'b1;
               redirect_pc_d = {mepc_q[31:2], 2'b00};
               state_d       = REDIRECT;
            end
         end
         REDIRECT: begin
            if (!stallControl) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_q       <= MTVEC_RESET;
         mscratch_q    <= 32'h0;
         mepc_q        <= 32'h0;
         mcause_q      <= 4'h0;
         mtval_q       <= 32'h0;
         mcycle_q      <= 64'h0;
         minstret_q    <= 64'h0;
         redirect_pc_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mcycle_q      <= mcycle_d;
         minstret_q    <= minstret_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign csrReadData   = csr_rdata;
   assign redirectValid = (state_q == REDIRECT);
   assign redirectPC    = redirect_pc_q;
   assign mstatusMIE    = mie_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Self-checking bench for trap_csr_unit: directed scenarios plus randomized
// traffic compared against a cycle-level model of the machine-mode CSR rules.
module tb_trap_csr_unit;

   localparam logic [31:0] MISA = 32'h4000_0100;
   localparam logic [31:0] HART = 32'h0;

   logic        clock;
   logic        reset;
   logic        trapTake;
   logic [3:0]  trapCause;
   logic [31:0] trapPC;
   logic [31:0] trapValue;
   logic        mretSignal;
   logic        stallControl;
   logic        retireValid;
   logic        csrValid;
   logic [1:0]  csrOp;
   logic [11:0] csrAddress;
   logic [31:0] csrWriteData;
   logic [31:0] csrReadData;
   logic        csrIllegal;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        mstatusMIE;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic        m_mie, m_mpie, m_redirect;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mtval, m_rpc;
   logic [3:0]  m_mcause;
   logic [63:0] m_mcycle, m_minstret;

   trap_csr_unit dut (
      .clock(clock), .reset(reset), .trapTake(trapTake), .trapCause(trapCause),
      .trapPC(trapPC), .trapValue(trapValue), .mretSignal(mretSignal),
      .stallControl(stallControl), .retireValid(retireValid), .csrValid(csrValid),
      .csrOp(csrOp), .csrAddress(csrAddress), .csrWriteData(csrWriteData),
      .csrReadData(csrReadData), .csrIllegal(csrIllegal), .redirectValid(redirectValid),
      .redirectPC(redirectPC), .mstatusMIE(mstatusMIE)
   );

   initial begin
      clock = 1'b0;
      forever #10 clock = ~clock;
   end

   task automatic drive_idle();
      trapTake = 0; trapCause = 0; trapPC = 0; trapValue = 0; mretSignal = 0;
      stallControl = 0; retireValid = 0; csrValid = 0; csrOp = 0;
      csrAddress = 0; csrWriteData = 0;
   endtask

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_redirect = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mtval = 0; m_rpc = 0; m_mcause = 0; m_mcycle = 0; m_minstret = 0;
   endtask

   function automatic logic m_known(input logic [11:0] a);
      return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                       12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a)
         12'h300: begin r = 32'h1800; r[7] = m_mpie; r[3] = m_mie; end
         12'h301: r = MISA;
         12'h305: r = m_mtvec & ~32'h3;
         12'h340: r = m_mscratch;
         12'h341: r = m_mepc & ~32'h3;
         12'h342: r = {28'h0, m_mcause};
         12'h343: r = m_mtval;
         12'hB00: r = m_mcycle[31:0];
         12'hB80: r = m_mcycle[63:32];
         12'hB02: r = m_minstret[31:0];
         12'hB82: r = m_minstret[63:32];
         12'hF14: r = HART;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic m_illegal();
      logic ro, modifies;
      ro       = (csrAddress == 12'h301) || (csrAddress == 12'hF14);
      modifies = (csrOp == 2'd1) || (csrOp >= 2'd2 && csrWriteData != 0);
      return csrValid && (!m_known(csrAddress) || (ro && modifies));
   endfunction

   // Advance one clock: model decides from the inputs as driven now, then commits after the edge.
   task automatic step();
      logic        n_mie, n_mpie, n_redirect;
      logic [31:0] n_mtvec, n_mscratch, n_mepc, n_mtval, n_rpc, nv;
      logic [3:0]  n_mcause;
      logic [63:0] n_mcycle, n_minstret;
      n_mie = m_mie; n_mpie = m_mpie; n_redirect = m_redirect; n_mtvec = m_mtvec;
      n_mscratch = m_mscratch; n_mepc = m_mepc; n_mtval = m_mtval; n_rpc = m_rpc;
      n_mcause = m_mcause;
      n_mcycle = m_mcycle + 1;
      n_minstret = m_minstret + (retireValid ? 1 : 0);
      if (csrValid && csrOp != 0 && !stallControl && !trapTake && !m_illegal()) begin
         nv = (csrOp == 1) ? csrWriteData :
              (csrOp == 2) ? (m_read(csrAddress) | csrWriteData) : (m_read(csrAddress) & ~csrWriteData);
         case (csrAddress)
            12'h300: begin n_mie = nv[3]; n_mpie = nv[7]; end
            12'h305: n_mtvec = nv;
            12'h340: n_mscratch = nv;
            12'h341: n_mepc = nv;
            12'h342: n_mcause = nv[3:0];
            12'h343: n_mtval = nv;
            12'hB00: n_mcycle = {m_mcycle[63:32], nv};
            12'hB80: n_mcycle = {nv, m_mcycle[31:0]};
            12'hB02: n_minstret = {m_minstret[63:32], nv};
            12'hB82: n_minstret = {nv, m_minstret[31:0]};
            default: ;
         endcase
      end
      if (!m_redirect) begin
         if (trapTake) begin
            n_mepc = trapPC & ~32'h3; n_mcause = trapCause; n_mtval = trapValue;
            n_mpie = m_mie; n_mie = 0; n_rpc = m_mtvec & ~32'h3; n_redirect = 1;
         end else if (mretSignal) begin
            n_mie = m_mpie; n_mpie = 1; n_rpc = m_mepc & ~32'h3; n_redirect = 1;
         end
      end else if (!stallControl) begin
         n_redirect = 0;
      end
      @(posedge clock);
      #1;
      m_mie = n_mie; m_mpie = n_mpie; m_redirect = n_redirect; m_mtvec = n_mtvec;
      m_mscratch = n_mscratch; m_mepc = n_mepc; m_mtval = n_mtval; m_rpc = n_rpc;
      m_mcause = n_mcause; m_mcycle = n_mcycle; m_minstret = n_minstret;
      drive_idle();
   endtask

   task automatic peek(input logic [11:0] a, output logic [31:0] d);
      csrValid = 0; csrOp = 0; csrAddress = a;
      #1;
      d = csrReadData;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      csrValid = 1; csrOp = op; csrAddress = a; csrWriteData = d;
      step();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 0;
      drive_idle();
      @(posedge clock);
      #1;
      checks++;
      if (redirectValid !== 1'b0 || redirectPC !== 32'h0 || mstatusMIE !== 1'b0) begin
         $display("FAIL reset_outputs got=%b/%h/%b exp=0/00000000/0", redirectValid, redirectPC, mstatusMIE);
         failures++;
      end
      reset = 1;
      model_reset();
      peek(12'h305, d);
      checks++;
      if (d !== 32'h0) begin $display("FAIL reset_mtvec got=%h exp=00000000", d); failures++; end
      peek(12'h300, d);
      checks++;
      if (d !== 32'h1800) begin $display("FAIL reset_mstatus got=%h exp=00001800", d); failures++; end
   endtask

   task automatic test_trap_entry();
      logic [31:0] d;
      trapTake = 1; trapCause = 4'd2; trapPC = 32'h104; trapValue = 32'hFFFF_FFFF;
      step();
      checks++;
      if (redirectValid !== 1'b1 || redirectPC !== 32'h0) begin
         $display("FAIL trap_redirect got=%b/%h exp=1/00000000", redirectValid, redirectPC);
         failures++;
      end
      peek(12'h341, d);
      checks++;
      if (d !== 32'h104) begin $display("FAIL trap_mepc got=%h exp=00000104", d); failures++; end
      peek(12'h342, d);
      checks++;
      if (d !== 32'h2) begin $display("FAIL trap_mcause got=%h exp=00000002", d); failures++; end
      peek(12'h343, d);
      checks++;
      if (d !== 32'hFFFF_FFFF) begin $display("FAIL trap_mtval got=%h exp=ffffffff", d); failures++; end
      peek(12'h300, d);
      checks++;
      if (d !== 32'h1800) begin $display("FAIL trap_mstatus got=%h exp=00001800", d); failures++; end
      step();
      checks++;
      if (redirectValid !== 1'b0) begin $display("FAIL trap_release got=%b exp=0", redirectValid); failures++; end
   endtask

   task automatic test_stall_redirect();
      logic [31:0] d;
      csr_write(12'h305, 2'd1, 32'h203);
      peek(12'h305, d);
      checks++;
      if (d !== 32'h200) begin $display("FAIL mtvec_mask got=%h exp=00000200", d); failures++; end
      trapTake = 1; trapCause = 4'd5; trapPC = 32'h400;
      step();
      checks++;
      if (redirectValid !== 1'b1 || redirectPC !== 32'h200) begin
         $display("FAIL stall_first got=%b/%h exp=1/00000200", redirectValid, redirectPC);
         failures++;
      end
      for (int i = 0; i < 3; i++) begin
         stallControl = 1;
         trapTake = 1;
         step();
         checks++;
         if (redirectValid !== 1'b1 || redirectPC !== 32'h200) begin
            $display("FAIL stall_hold%0d got=%b/%h exp=1/00000200", i, redirectValid, redirectPC);
            failures++;
         end
      end
      step();
      checks++;
      if (redirectValid !== 1'b0) begin $display("FAIL stall_release got=%b exp=0", redirectValid); failures++; end
   endtask

   task automatic test_mret();
      logic [31:0] d;
      csr_write(12'h300, 2'd2, 32'h8);
      checks++;
      if (mstatusMIE !== 1'b1) begin $display("FAIL mret_setmie got=%b exp=1", mstatusMIE); failures++; end
      trapTake = 1; trapCause = 4'd11; trapPC = 32'h302;
      step();
      peek(12'h300, d);
      checks++;
      if (mstatusMIE !== 1'b0 || d !== 32'h1880) begin
         $display("FAIL mret_after_trap got=%b/%h exp=0/00001880", mstatusMIE, d);
         failures++;
      end
      step();
      mretSignal = 1;
      step();
      peek(12'h300, d);
      checks++;
      if (redirectValid !== 1'b1 || redirectPC !== 32'h300 || mstatusMIE !== 1'b1 || d !== 32'h1888) begin
         $display("FAIL mret_restore got=%b/%h/%b/%h exp=1/00000300/1/00001888",
                  redirectValid, redirectPC, mstatusMIE, d);
         failures++;
      end
      step();
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      csr_write(12'h340, 2'd1, 32'h1234);
      trapTake = 1; mretSignal = 1; trapCause = 4'd3; trapPC = 32'h888;
      csrValid = 1; csrOp = 2'd1; csrAddress = 12'h340; csrWriteData = 32'hDEAD;
      step();
      checks++;
      if (redirectValid !== 1'b1 || redirectPC !== 32'h200) begin
         $display("FAIL simul_redirect got=%b/%h exp=1/00000200", redirectValid, redirectPC);
         failures++;
      end
      peek(12'h340, d);
      checks++;
      if (d !== 32'h1234) begin $display("FAIL simul_mscratch got=%h exp=00001234", d); failures++; end
      peek(12'h341, d);
      checks++;
      if (d !== 32'h888) begin $display("FAIL simul_mepc got=%h exp=00000888", d); failures++; end
      step();
   endtask

   task automatic test_illegal();
      logic [31:0] d;
      csrValid = 1; csrOp = 2'd1; csrAddress = 12'hF14; csrWriteData = 32'h5;
      #1;
      checks++;
      if (csrIllegal !== 1'b1) begin $display("FAIL ill_hartid_write got=%b exp=1", csrIllegal); failures++; end
      step();
      peek(12'hF14, d);
      checks++;
      if (d !== HART) begin $display("FAIL ill_hartid_keep got=%h exp=%h", d, HART); failures++; end
      csrValid = 1; csrOp = 2'd2; csrAddress = 12'hF14; csrWriteData = 32'h0;
      #1;
      checks++;
      if (csrIllegal !== 1'b0 || csrReadData !== HART) begin
         $display("FAIL ill_hartid_set0 got=%b/%h exp=0/%h", csrIllegal, csrReadData, HART);
         failures++;
      end
      csrOp = 2'd3; csrAddress = 12'h301; csrWriteData = 32'h1;
      #1;
      checks++;
      if (csrIllegal !== 1'b1) begin $display("FAIL ill_misa_clear got=%b exp=1", csrIllegal); failures++; end
      csrOp = 2'd0; csrAddress = 12'h7C0;
      #1;
      checks++;
      if (csrIllegal !== 1'b1) begin $display("FAIL ill_unknown got=%b exp=1", csrIllegal); failures++; end
      step();
   endtask

   task automatic test_counter_wrap();
      logic [31:0] lo, hi;
      csr_write(12'hB00, 2'd1, 32'hFFFF_FFFF);
      csr_write(12'hB80, 2'd1, 32'hFFFF_FFFF);
      peek(12'hB00, lo);
      peek(12'hB80, hi);
      checks++;
      if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFF) begin
         $display("FAIL mcycle_max got=%h_%h exp=ffffffff_ffffffff", hi, lo);
         failures++;
      end
      step();
      peek(12'hB00, lo);
      peek(12'hB80, hi);
      checks++;
      if (lo !== 32'h0 || hi !== 32'h0) begin
         $display("FAIL mcycle_wrap got=%h_%h exp=00000000_00000000", hi, lo);
         failures++;
      end
   endtask

   task automatic test_random();
      logic [11:0] addrs [14] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h123};
      for (int i = 0; i < 300; i++) begin
         trapTake     = ($urandom_range(0, 9) == 0);
         trapCause    = 4'($urandom);
         trapPC       = $urandom;
         trapValue    = $urandom;
         mretSignal   = ($urandom_range(0, 7) == 0);
         stallControl = ($urandom_range(0, 3) == 0);
         retireValid  = 1'($urandom);
         csrValid     = 1'($urandom);
         csrOp        = 2'($urandom);
         csrAddress   = addrs[$urandom_range(0, 13)];
         csrWriteData = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         #1;
         checks++;
         if (csrIllegal !== m_illegal()) begin
            $display("FAIL rnd_illegal[%0d] got=%b exp=%b", i, csrIllegal, m_illegal()); failures++;
         end
         checks++;
         if (csrReadData !== m_read(csrAddress)) begin
            $display("FAIL rnd_rdata[%0d] addr=%h got=%h exp=%h", i, csrAddress, csrReadData, m_read(csrAddress));
            failures++;
         end
         checks++;
         if (redirectValid !== m_redirect || redirectPC !== m_rpc || mstatusMIE !== m_mie) begin
            $display("FAIL rnd_state[%0d] got=%b/%h/%b exp=%b/%h/%b", i, redirectValid, redirectPC,
                     mstatusMIE, m_redirect, m_rpc, m_mie);
            failures++;
         end
         step();
      end
   endtask

   task automatic test_reset_mid_redirect();
      logic [31:0] d;
      stallControl = 1;
      step();
      trapTake = 1; trapPC = 32'h500;
      step();
      checks++;
      if (redirectValid !== 1'b1) begin $display("FAIL midrst_pre got=%b exp=1", redirectValid); failures++; end
      reset = 0;
      #1;
      checks++;
      if (redirectValid !== 1'b0 || redirectPC !== 32'h0) begin
         $display("FAIL midrst_async got=%b/%h exp=0/00000000", redirectValid, redirectPC);
         failures++;
      end
      model_reset();
      @(posedge clock);
      #1;
      reset = 1;
      peek(12'hB00, d);
      checks++;
      if (d !== 32'h0) begin $display("FAIL midrst_mcycle got=%h exp=00000000", d); failures++; end
   endtask

   initial begin
      drive_idle();
      model_reset();
      reset = 0;
      test_reset();
      test_trap_entry();
      test_stall_redirect();
      test_mret();
      test_simultaneous();
      test_illegal();
      test_counter_wrap();
      test_random();
      test_reset_mid_redirect();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
Machine-mode trap and CSR unit that sits directly downstream of the pipeline hazard/trap controller. It consumes that controller's trap-take pulse and 4-bit cause and the mret request. On a trap it saves machine state and redirects fetch to mtvec; on mret it restores state and redirects fetch to mepc. It also services Zicsr reads and writes from the execute stage and keeps the mcycle/minstret counters.

Parameters:
MTVEC_RESET, 32'h0000_0000, mtvec value after reset (trap vector base).
HART_ID, 0, value returned by mhartid.
MISA_VALUE, 32'h4000_0100, value returned by misa (RV32I).

Ports:
clock  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low; reset==0 clears all state immediately.
trapTake  input  1  trap-take pulse (controlReset) from the hazard controller.
trapCause  input  4  exception code (mcause) from the hazard controller.
trapPC  input  32  PC of the faulting instruction.
trapValue  input  32  faulting address or instruction word, written to mtval.
mretSignal  input  1  mret is executing.
stallControl  input  1  global pipeline stall.
retireValid  input  1  one instruction retires this cycle.
csrValid  input  1  CSR instruction is valid in execute.
csrOp  input  2  0=none, 1=write, 2=set, 3=clear.
csrAddress  input  12  CSR address.
csrWriteData  input  32  rs1 value or zero-extended immediate.
csrReadData  output  32  combinational read of the addressed CSR (old value).
csrIllegal  output  1  combinational: unknown address, or write to a read-only CSR.
redirectValid  output  1  registered; fetch must load redirectPC.
redirectPC  output  32  registered redirect target.
mstatusMIE  output  1  current mstatus.MIE.

Behaviour:
- CSR map:
  - 0x300 mstatus: MIE is bit 3, MPIE is bit 7, MPP (bits 12:11) reads 2'b11; all other bits read 0.
  - 0x301 misa: read-only.
  - 0x305 mtvec: direct mode only; bits 1:0 read 0.
  - 0x340 mscratch.
  - 0x341 mepc: bits 1:0 read 0.
  - 0x342 mcause: bit 31 reads 0; bits 3:0 are stored.
  - 0x343 mtval.
  - 0xB00/0xB80 mcycle low/high.
  - 0xB02/0xB82 minstret low/high.
  - 0xF14 mhartid: read-only.
- csrIllegal:
  - Asserts for any unlisted address while csrValid.
  - Asserts for a read-only address when csrOp==write, or when csrOp is set/clear with csrWriteData != 0.
  - An illegal access performs no update.
- CSR update: new value = writeData (write), old | writeData (set), old & ~writeData (clear). Applied at the clock edge when csrValid && !stallControl && !trapTake && !csrIllegal.
- Reset values: mstatus=0, mtvec=MTVEC_RESET, mscratch=0, mepc=0, mcause=0, mtval=0, mcycle=0, minstret=0, redirectValid=0, redirectPC=0, FSM=IDLE.
- FSM states IDLE, REDIRECT.
- Trap entry: in IDLE, trapTake==1 at an edge does all of the following:
  - mepc <= trapPC & ~3; mcause <= {28'b0, trapCause}; mtval <= trapValue.
  - MPIE <= MIE; MIE <= 0.
  - redirectPC <= mtvec & ~3; go to REDIRECT.
- mret: in IDLE, mretSignal && !trapTake at an edge does MIE <= MPIE, MPIE <= 1, redirectPC <= mepc; go to REDIRECT.
- Simultaneous events:
  - trapTake and mretSignal together: the trap wins and mret is ignored.
  - trapTake and a CSR write together: the CSR write is dropped.
- REDIRECT:
  - redirectValid=1; redirectPC is held.
  - Returns to IDLE at the first edge with stallControl==0.
  - trapTake and mretSignal are ignored in this state; the pipeline is already flushed.
- Latency: a trap or mret sampled at edge N gives redirectValid=1 during cycle N+1.
- Counters:
  - mcycle increments every cycle and minstret increments when retireValid; both are 64-bit and wrap to 0.
  - A CSR write to either half replaces that half that cycle and suppresses the increment for that cycle.
- Mid-operation reset: reset low in any state returns everything to reset values asynchronously. redirectValid drops immediately.

Test Plan:
- Reset with mtvec default, then trapTake with cause 2, trapPC 0x104 and trapValue 0xFFFFFFFF -> next cycle redirectValid=1 and redirectPC=0x0; mepc=0x104, mcause=2, mtval=0xFFFFFFFF; MPIE=old MIE, MIE=0.
- Write mtvec=0x203, take a trap, then hold stallControl=1 for 3 cycles -> redirectPC=0x200; redirectValid stays 1 for 4 cycles, then 0.
- Set mstatus bit 3, trap, then mret -> after the trap MIE=0 and MPIE=1; after mret redirectPC=mepc, MIE=1 and MPIE=1.
- trapTake and mretSignal in the same cycle with a CSR write to mscratch -> trap path taken, mscratch unchanged, redirectPC=mtvec.
- csrOp=write to 0xF14 -> csrIllegal=1 and no change; set to 0xF14 with data 0 -> csrIllegal=0 and csrReadData=HART_ID; address 0x7C0 -> csrIllegal=1.
- Write mcycle low=0xFFFFFFFF and high=0xFFFFFFFF, then let 1 cycle pass -> mcycle reads 0; assert reset mid-REDIRECT -> redirectValid=0 immediately.
